// File: rtl/morse_pkg.sv
// Shared symbol encoding, FSM states and timing helpers
// for the Morse symbol scheduler.
package morse_pkg;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int ms_to_cycles(input int freq_hz, input int ms);
    return (freq_hz / 1000) * ms;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/morse_symbol_fifo.sv
// Synchronous 1-bit symbol FIFO; a push is still accepted
// when full if a pop happens in the same cycle.
module morse_symbol_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (wr_en) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/morse_symbol_scheduler.sv
// Buffers DOT/DASH presses and plays them on the LED with exact timing.
// Optional input debounce: define MORSE_DEBOUNCE_EN.
module morse_symbol_scheduler
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int DOT_MS      = 250,
  parameter int DASH_MS     = 750,
  parameter int GAP_MS      = 250,
  parameter int DEBOUNCE_MS = 10,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  pushButton,
  output logic                        LED,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                        overflow,
  output logic                        conflict
);

  localparam int FCW      = $clog2(FIFO_DEPTH) + 1;
  localparam int DOT_CYC  = ms_to_cycles(CLOCK_FREQ, DOT_MS);
  localparam int DASH_CYC = ms_to_cycles(CLOCK_FREQ, DASH_MS);
  localparam int GAP_CYC  = ms_to_cycles(CLOCK_FREQ, GAP_MS);
  localparam int MAX_CYC  = max3(DOT_CYC, DASH_CYC, GAP_CYC);
  localparam int CNT_W    = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_CYC);
  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_CYC);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DEBOUNCE_MS < 0 || CLOCK_FREQ < 1000) begin : g_cfg_err
    $error("morse_symbol_scheduler: bad parameter set");
  end

  // Reset asserts at once but releases in step with the clock.
  logic [1:0] rst_q;
  logic       rst_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  end

  assign rst_i = rst_q[1];

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] lvl;

  assign sync1_d = pushButton;
  assign sync2_d = sync1_q;

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DB_CYC = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);
  localparam int DB_LIM = (DB_CYC > 1) ? DB_CYC - 1 : 0;
  localparam int DBW    = $clog2(DB_LIM + 1) + 1;

  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          db_lvl_q, db_lvl_d;

  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DBW'(DB_LIM)) db_lvl_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
      db_lvl_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign lvl = db_lvl_q;
`else
  assign lvl = sync2_q;
`endif

  logic [1:0] prev_q, prev_d;
  logic [1:0] rise_q, rise_d;

  assign prev_d = lvl;
  assign rise_d = lvl & ~prev_q;

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  logic           push_req, push_sym;
  logic           pop;
  logic           fifo_dout, fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_cnt;

  assign push_req = rise_q[1] ^ rise_q[0];
  assign push_sym = rise_q[0] ? SYM_DASH : SYM_DOT;
  assign conflict = rise_q[1] & rise_q[0];
  assign overflow = push_req & fifo_full & ~pop;

  morse_symbol_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clock (clock),
    .reset (rst_i),
    .push  (push_req),
    .pop   (pop),
    .din   (push_sym),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sym_len;

  assign sym_len = (fifo_dout == SYM_DASH) ? DASH_C : DOT_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = sym_len;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (cnt_q == ONE_C) begin
          cnt_d   = GAP_C;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      ST_GAP: begin
        if (cnt_q != ONE_C) begin
          cnt_d = cnt_q - ONE_C;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = sym_len;
          state_d = ST_ON;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LED       = (state_q == ST_ON);
  assign busy      = (state_q != ST_IDLE) | (fifo_cnt != '0);
  assign fifoCount = fifo_cnt;

endmodule

// File: tb/tb_morse_symbol_scheduler.sv
// Directed bench for morse_symbol_scheduler at 1 cycle per ms.
// Define MORSE_DEBOUNCE_EN to exercise the debounced build.
module tb_morse_symbol_scheduler;

`ifdef MORSE_DEBOUNCE_EN
  localparam int DB = 10;
`else
  localparam int DB = 0;
`endif
  localparam int PH = 2 + DB;
  localparam int RL = 2 + DB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pushButton = 2'b00;
  logic       LED, busy, overflow, conflict;
  logic [3:0] fifoCount;

  always #5 clock = ~clock;

  morse_symbol_scheduler #(
    .CLOCK_FREQ  (1000),
    .DOT_MS      (250),
    .DASH_MS     (750),
    .GAP_MS      (250),
    .DEBOUNCE_MS (10),
    .FIFO_DEPTH  (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pushButton (pushButton),
    .LED        (LED),
    .busy       (busy),
    .fifoCount  (fifoCount),
    .overflow   (overflow),
    .conflict   (conflict)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int  run = 0;
  logic led_prev = 1'b0;
  int  on_q[$];
  int  off_q[$];
  int  n_ovf = 0;
  int  n_cfl = 0;
  int  peak = 0;

  always @(negedge clock) begin
    if (reset) begin
      run = 0;
      led_prev = 1'b0;
    end else begin
      if (LED !== led_prev) begin
        if (led_prev) on_q.push_back(run);
        else off_q.push_back(run);
        run = 1;
      end else begin
        run++;
      end
      led_prev = LED;
      if (overflow) n_ovf++;
      if (conflict) n_cfl++;
      if (int'(fifoCount) > peak) peak = int'(fifoCount);
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_mon();
    @(posedge clock);
    on_q.delete();
    off_q.delete();
    n_ovf = 0;
    n_cfl = 0;
    peak = 0;
  endtask

  task automatic press(input logic [1:0] v, input int n);
    pushButton = v;
    repeat (n) @(negedge clock);
    pushButton = 2'b00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((busy || k < 30) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int rise, tail, n750, k;

    repeat (3) @(negedge clock);
    chk("rst_led", int'(LED), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(fifoCount), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_cfl", int'(conflict), 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // single dot: latency, on-time, trailing gap
    clear_mon();
    @(negedge clock);
    pushButton = 2'b10;
    rise = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 5 + DB) pushButton = 2'b00;
      if (LED && rise < 0) rise = i;
    end
    chk("dot_latency", rise - 1, 4 + DB);
    k = 0;
    while (LED && k < 2000) begin
      @(negedge clock);
      k++;
    end
    tail = 0;
    while (busy && tail < 2000) begin
      tail++;
      @(negedge clock);
    end
    chk("dot_busy_tail", tail, 250);
    wait_idle("dot", 2000);
    chk("dot_on_n", on_q.size(), 1);
    chk("dot_on_len", qget(on_q, 0), 250);
    chk("dot_peak", peak, 1);

    // dot, dash, dot back to back
    clear_mon();
    @(negedge clock);
    press(2'b10, PH);
    repeat (RL) @(negedge clock);
    press(2'b01, PH);
    repeat (RL) @(negedge clock);
    press(2'b10, PH);
    wait_idle("seq", 4000);
    chk("seq_on_n", on_q.size(), 3);
    chk("seq_on0", qget(on_q, 0), 250);
    chk("seq_on1", qget(on_q, 1), 750);
    chk("seq_on2", qget(on_q, 2), 250);
    chk("seq_gap0", qget(off_q, 1), 250);
    chk("seq_gap1", qget(off_q, 2), 250);

    // simultaneous edges
    clear_mon();
    @(negedge clock);
    press(2'b11, PH);
    repeat (10) @(negedge clock);
    chk("cfl_pulses", n_cfl, 1);
    chk("cfl_count", int'(fifoCount), 0);
    chk("cfl_led", int'(LED), 0);
    chk("cfl_busy", int'(busy), 0);
    chk("cfl_peak", peak, 0);

`ifdef MORSE_DEBOUNCE_EN
    clear_mon();
    @(negedge clock);
    press(2'b10, 5);
    repeat (40) @(negedge clock);
    chk("glitch_peak", peak, 0);
    chk("glitch_led", int'(LED), 0);
`endif

    // ten dashes into an 8-deep queue
    clear_mon();
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      press(2'b01, PH);
      repeat (RL) @(negedge clock);
    end
    repeat (10) @(negedge clock);
    chk("ovf_count", int'(fifoCount), 8);
    chk("ovf_pulses", n_ovf, 1);
    chk("ovf_peak", peak, 8);
    wait_idle("ovf", 12000);
    chk("ovf_played", on_q.size(), 9);
    n750 = 0;
    foreach (on_q[i]) if (on_q[i] == 750) n750++;
    chk("ovf_all_dash", n750, 9);
    chk("ovf_gap", qget(off_q, 4), 250);

    // reset in the middle of a dash
    clear_mon();
    @(negedge clock);
    press(2'b01, PH);
    repeat (RL) @(negedge clock);
    press(2'b01, PH);
    k = 0;
    while (!LED && k < 60) begin
      @(negedge clock);
      k++;
    end
    repeat (100) @(negedge clock);
    chk("pre_rst_led", int'(LED), 1);
    chk("pre_rst_count", int'(fifoCount), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_led", int'(LED), 0);
    chk("mid_rst_count", int'(fifoCount), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    clear_mon();
    @(negedge clock);
    press(2'b10, PH);
    wait_idle("post_rst", 2000);
    chk("post_rst_on_n", on_q.size(), 1);
    chk("post_rst_len", qget(on_q, 0), 250);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/morse_symbol_scheduler.md
# morse_symbol_scheduler

Queues Morse symbols entered on the DOT/DASH push buttons and sequences the Morse LED so each symbol plays back with exact on-time and inter-symbol gap, even when buttons are pressed faster than playback. Sits between the raw push-button inputs and the LED pin. It replaces direct button-to-LED timing with a buffered, conflict-checked scheduler.

## Interface
- CLOCK_FREQ, 50_000_000, clock frequency in Hz
- DOT_MS, 250, LED on-time for a dot
- DASH_MS, 750, LED on-time for a dash
- GAP_MS, 250, LED off-time after every symbol
- DEBOUNCE_MS, 10, stability window (used only with debounce compiled in)
- FIFO_DEPTH, 8, symbol queue depth; power of two, ≥2
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- pushButton  input  2  bit1 = DOT, bit0 = DASH; asynchronous, active-high
- LED  output  1  Morse LED drive
- busy  output  1  high while a symbol or gap is playing or the FIFO is non-empty
- fifoCount  output  $clog2(FIFO_DEPTH)+1  queued symbols not yet started
- overflow  output  1  one-cycle pulse: press dropped because FIFO full
- conflict  output  1  one-cycle pulse: DOT and DASH edges in same cycle, both dropped

## Operation
- Each pushButton bit: 2-FF synchroniser, then rising-edge detect (one-cycle pulse per press; holding a button queues one symbol).
- Edge resolution: DOT only -> push 0; DASH only -> push 1; both -> no push, conflict pulse.
- FIFO: 1-bit symbols, 0 = dot, 1 = dash.
  - Push when full with no pop that cycle -> dropped, overflow pulse.
  - Push and pop same cycle when full -> both accepted, count unchanged.
  - Push and pop same cycle when empty -> not possible; pop requires non-empty.
- FSM states: IDLE, ON, GAP.
  - IDLE: LED=0. FIFO non-empty -> pop; load counter with DOT_CYCLES or DASH_CYCLES; go to ON.
  - ON: LED=1. Counter decrements; at 1 -> load GAP_CYCLES, go to GAP.
  - GAP: LED=0. At 1 -> FIFO non-empty: pop, load, go to ON directly; else IDLE.
- X_CYCLES = CLOCK_FREQ/1000 × X_MS, computed at elaboration. Counter width = $clog2(max of the three)+1.
- Counter never wraps; decrement only in ON/GAP.
- busy = (state≠IDLE) | (fifoCount≠0).

## Timing
- Reset values: LED=0, busy=0, fifoCount=0, overflow=0, conflict=0, state IDLE, FIFO and synchronisers cleared.
- Assertion of reset forces LED low immediately, mid-symbol included. Deassertion is synchronised; first press accepted ≥2 cycles after release.
- Latency, no debounce, idle and empty: pushButton high sampled at edge N -> FIFO push at edge N+3 -> LED high from edge N+4.
- LED high for exactly DOT_CYCLES / DASH_CYCLES clocks.
- LED low for exactly GAP_CYCLES clocks between back-to-back symbols.
- fifoCount updates the edge after push/pop.
- overflow/conflict coincide with the edge-detect cycle.

## Configuration
- MORSE_DEBOUNCE_EN defined: after synchronisation, each bit must remain stable for DEBOUNCE_CYCLES before its level updates. Edge detect runs on the debounced level. Latency grows by DEBOUNCE_CYCLES. Glitches shorter than the window produce no symbol.
- Undefined: no debounce logic instantiated; DEBOUNCE_MS ignored; latency as stated under Timing.

## Structure
- Shared package morse_pkg: symbol encoding (SYM_DOT=0, SYM_DASH=1), FSM state encodings, ms-to-cycles constant function.
- Sub-module morse_symbol_fifo: synchronous, parameterised depth, full/empty/count, same-cycle push+pop when full.
- Synchroniser, debounce, edge detect, and FSM live in the top.

## Test plan
Use CLOCK_FREQ=1000, so 1 cycle = 1 ms and DOT=250, DASH=750, GAP=250 cycles.
- DOT press (2'b10 for 5 cycles) from idle -> LED high 4 edges later, for exactly 250 cycles; busy falls 250 cycles after LED falls; fifoCount peaks at 1.
- DOT, DASH, DOT presses within 10 cycles -> LED pattern 250 on / 250 off / 750 on / 250 off / 250 on; no IDLE between symbols.
- Pressing 2'b11 in one cycle -> one conflict pulse; fifoCount stays 0; LED stays 0.
- 10 distinct DASH presses while the first plays, FIFO_DEPTH=8 -> first popped; 8 queued; 1 overflow pulse; 9 dashes played in total.
- reset asserted 100 cycles into a dash -> LED=0 without waiting for a clock edge; fifoCount=0. After release, a new DOT plays normally.
- MORSE_DEBOUNCE_EN, DEBOUNCE_MS=10: a 5-cycle DOT pulse -> no symbol. A 15-cycle pulse -> one dot, LED rising 10 cycles later than without debounce.
